// File: rtl/stage_controller.sv
// Multi-cycle stage sequencer: one-hot stage enables with variable-latency memory
// handshake, execute stall, memory timeout, fault halt and cycle/instret counters.
module stage_controller #(
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter int unsigned MEM_TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     decode_rd_rf_enabled,
    input  logic                     decode_ma_mem_enabled,
    input  logic                     ex_busy,
    input  logic                     mem_ack,
    input  logic                     fault_in,
    output logic                     mem_req,
    output logic                     stage_is_fetch,
    output logic                     stage_is_decode,
    output logic                     stage_is_read,
    output logic                     stage_is_execute,
    output logic                     stage_is_memory,
    output logic                     stage_is_write_back,
    output logic                     halted,
    output logic                     timeout_fault,
    output logic [COUNTER_WIDTH-1:0] cycle_count,
    output logic [COUNTER_WIDTH-1:0] instret_count
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_DECODE     = 3'd1,
        S_READ       = 3'd2,
        S_EXECUTE    = 3'd3,
        S_MEMORY     = 3'd4,
        S_WRITE_BACK = 3'd5,
        S_HALT       = 3'd6
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                wait_last;
    logic                timeout_hit;
    logic                retire;

    // Last permitted wait cycle: the MEM_TIMEOUT-th cycle spent in FETCH/MEMORY.
    assign wait_last = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        retire      = 1'b0;
        case (state)
            S_FETCH: begin
                if (mem_ack) begin
                    state_next = S_DECODE;
                end else if (wait_last) begin
                    state_next  = S_HALT;
                    timeout_hit = 1'b1;
                end
            end
            S_DECODE:  state_next = decode_rd_rf_enabled ? S_READ : S_EXECUTE;
            S_READ:    state_next = S_EXECUTE;
            S_EXECUTE: begin
                if (!ex_busy) begin
                    state_next = decode_ma_mem_enabled ? S_MEMORY : S_WRITE_BACK;
                end
            end
            S_MEMORY: begin
                if (mem_ack) begin
                    state_next = S_WRITE_BACK;
                end else if (wait_last) begin
                    state_next  = S_HALT;
                    timeout_hit = 1'b1;
                end
            end
            S_WRITE_BACK: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_HALT;
        endcase
        // A unit fault overrides every other transition and suppresses retire/timeout.
        if (fault_in && state != S_HALT) begin
            state_next  = S_HALT;
            timeout_hit = 1'b0;
            retire      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= S_FETCH;
            wait_cnt            <= '0;
            halted              <= 1'b0;
            timeout_fault       <= 1'b0;
            cycle_count         <= '0;
            instret_count       <= '0;
            stage_is_fetch      <= 1'b1;
            stage_is_decode     <= 1'b0;
            stage_is_read       <= 1'b0;
            stage_is_execute    <= 1'b0;
            stage_is_memory     <= 1'b0;
            stage_is_write_back <= 1'b0;
        end else begin
            state               <= state_next;
            halted              <= (state_next == S_HALT);
            timeout_fault       <= timeout_fault | timeout_hit;
            stage_is_fetch      <= (state_next == S_FETCH);
            stage_is_decode     <= (state_next == S_DECODE);
            stage_is_read       <= (state_next == S_READ);
            stage_is_execute    <= (state_next == S_EXECUTE);
            stage_is_memory     <= (state_next == S_MEMORY);
            stage_is_write_back <= (state_next == S_WRITE_BACK);

            // Staying in FETCH/MEMORY implies no ack; any stage change restarts the count.
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (state == S_FETCH || state == S_MEMORY) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            if (state != S_HALT) begin
                cycle_count <= cycle_count + COUNTER_WIDTH'(1);
            end
            if (retire) begin
                instret_count <= instret_count + COUNTER_WIDTH'(1);
            end
        end
    end

    assign mem_req = stage_is_fetch | stage_is_memory;

endmodule

// File: tb/tb_stage_controller.sv
// Scoreboard bench for stage_controller: per-instruction stage timelines are derived
// from handshake/stall/fault rules, queued per cycle, and checked by a monitor.
module tb_stage_controller;

    localparam int unsigned CW = 6;
    localparam int unsigned T  = 4;

    logic          clk;
    logic          reset;
    logic          decode_rd_rf_enabled;
    logic          decode_ma_mem_enabled;
    logic          ex_busy;
    logic          mem_ack;
    logic          fault_in;
    logic          mem_req;
    logic          stage_is_fetch;
    logic          stage_is_decode;
    logic          stage_is_read;
    logic          stage_is_execute;
    logic          stage_is_memory;
    logic          stage_is_write_back;
    logic          halted;
    logic          timeout_fault;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] instret_count;

    stage_controller #(.COUNTER_WIDTH(CW), .MEM_TIMEOUT(T)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .decode_rd_rf_enabled  (decode_rd_rf_enabled),
        .decode_ma_mem_enabled (decode_ma_mem_enabled),
        .ex_busy               (ex_busy),
        .mem_ack               (mem_ack),
        .fault_in              (fault_in),
        .mem_req               (mem_req),
        .stage_is_fetch        (stage_is_fetch),
        .stage_is_decode       (stage_is_decode),
        .stage_is_read         (stage_is_read),
        .stage_is_execute      (stage_is_execute),
        .stage_is_memory       (stage_is_memory),
        .stage_is_write_back   (stage_is_write_back),
        .halted                (halted),
        .timeout_fault         (timeout_fault),
        .cycle_count           (cycle_count),
        .instret_count         (instret_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stage codes: 0 F, 1 D, 2 R, 3 E, 4 M, 5 W, 6 halt
    typedef struct {
        int            stg;
        logic [CW-1:0] cc;
        logic [CW-1:0] ir;
        bit            h;
        bit            tf;
    } exp_t;

    exp_t          expq[$];
    int            total = 0;
    int            bad   = 0;
    logic [CW-1:0] m_cc;
    logic [CW-1:0] m_ir;
    bit            m_h;
    bit            m_tf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            logic [5:0] ev;
            e  = expq.pop_front();
            ev = (e.stg == 6) ? 6'b0 : 6'(1 << e.stg);
            check("stages", 64'({stage_is_write_back, stage_is_memory, stage_is_execute,
                                 stage_is_read, stage_is_decode, stage_is_fetch}), 64'(ev));
            check("mem_req", 64'(mem_req), 64'(e.stg == 0 || e.stg == 4));
            check("halted", 64'(halted), 64'(e.h));
            check("timeout_fault", 64'(timeout_fault), 64'(e.tf));
            check("cycle_count", 64'(cycle_count), 64'(e.cc));
            check("instret_count", 64'(instret_count), 64'(e.ir));
        end
    end

    task automatic push_exp(input int stg);
        exp_t e;
        e.stg = stg;
        e.cc  = m_cc;
        e.ir  = m_ir;
        e.h   = m_h;
        e.tf  = m_tf;
        expq.push_back(e);
    endtask

    task automatic do_reset();
        reset                 = 1'b1;
        mem_ack               = 1'($urandom);
        ex_busy               = 1'($urandom);
        fault_in              = 1'($urandom);
        decode_rd_rf_enabled  = 1'($urandom);
        decode_ma_mem_enabled = 1'($urandom);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_cc  = '0;
        m_ir  = '0;
        m_h   = 1'b0;
        m_tf  = 1'b0;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            push_exp(6);
            mem_ack               = 1'($urandom);
            ex_busy               = 1'($urandom);
            fault_in              = 1'($urandom);
            decode_rd_rf_enabled  = 1'($urandom);
            decode_ma_mem_enabled = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    // fw/mw: cycles without ack before the ack; eb: busy cycles in execute.
    // fault_at: timeline index carrying fault_in (-1 none); stop_at: abandon before that index.
    task automatic run_instr(input bit rd, input bit ma, input int fw, input int eb,
                             input int mw, input int fault_at, input int stop_at);
        int stg[$];
        bit ack[$];
        bit busy[$];
        bit timed_out;
        bit faulted;
        int n;
        timed_out = 1'b0;
        faulted   = 1'b0;
        for (int i = 0; i <= fw && i < int'(T); i++) begin
            stg.push_back(0); ack.push_back(i == fw); busy.push_back(1'($urandom));
        end
        if (fw >= int'(T)) begin
            timed_out = 1'b1;
        end else begin
            stg.push_back(1); ack.push_back(1'($urandom)); busy.push_back(1'($urandom));
            if (rd) begin
                stg.push_back(2); ack.push_back(1'($urandom)); busy.push_back(1'($urandom));
            end
            for (int i = 0; i <= eb; i++) begin
                stg.push_back(3); ack.push_back(1'($urandom)); busy.push_back(i < eb);
            end
            if (ma) begin
                for (int i = 0; i <= mw && i < int'(T); i++) begin
                    stg.push_back(4); ack.push_back(i == mw); busy.push_back(1'($urandom));
                end
                if (mw >= int'(T)) timed_out = 1'b1;
            end
            if (!timed_out) begin
                stg.push_back(5); ack.push_back(1'($urandom)); busy.push_back(1'($urandom));
            end
        end
        n = stg.size();
        if (fault_at >= 0 && fault_at < n) begin
            n       = fault_at + 1;
            faulted = 1'b1;
        end
        for (int j = 0; j < n; j++) begin
            if (j == stop_at) return;
            push_exp(stg[j]);
            mem_ack               = ack[j];
            ex_busy               = busy[j];
            decode_rd_rf_enabled  = (stg[j] == 1) ? rd : 1'($urandom);
            decode_ma_mem_enabled = (stg[j] == 3 && !busy[j]) ? ma : 1'($urandom);
            fault_in              = faulted && (j == n - 1);
            @(posedge clk);
            #1;
            m_cc = m_cc + 1'b1;
        end
        fault_in = 1'b0;
        if (faulted) begin
            m_h = 1'b1;
        end else if (timed_out) begin
            m_h  = 1'b1;
            m_tf = 1'b1;
        end else begin
            m_ir = m_ir + 1'b1;
        end
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 9) == 0) ? int'(T) + int'($urandom_range(0, 1))
                                           : int'($urandom_range(0, T - 1));
    endfunction

    initial begin
        int guard;
        fault_in = 1'b0;
        do_reset();

        // ALU op, then load with ack on 3rd MEMORY cycle
        run_instr(1'b1, 1'b0, 0, 0, 0, -1, -1);
        run_instr(1'b1, 1'b1, 0, 0, 2, -1, -1);
        // fetch timeout
        run_instr(1'b0, 1'b0, T + 1, 0, 0, -1, -1);
        halt_cycles(3);
        do_reset();
        // fault in EXECUTE while busy
        run_instr(1'b1, 1'b0, 0, 2, 0, 3, -1);
        halt_cycles(2);
        do_reset();
        // fault coinciding with mem_ack in MEMORY
        run_instr(1'b0, 1'b0, 1, 0, 0, -1, -1);
        run_instr(1'b0, 1'b1, 0, 0, 1, 4, -1);
        halt_cycles(2);
        do_reset();
        // fault in WRITE_BACK is not retired
        run_instr(1'b0, 1'b0, 0, 0, 0, 3, -1);
        halt_cycles(1);
        do_reset();
        // reset in the middle of MEMORY
        run_instr(1'b1, 1'b1, 0, 0, 3, -1, 6);
        do_reset();
        run_instr(1'b0, 1'b1, 2, 1, 0, -1, -1);
        // memory timeout, then reset while halted
        run_instr(1'b1, 1'b1, 0, 1, T, -1, -1);
        halt_cycles(2);
        do_reset();
        // long clean run so both counters wrap
        for (int i = 0; i < 70; i++) begin
            run_instr(1'($urandom), 1'($urandom), int'($urandom_range(0, T - 1)),
                      int'($urandom_range(1, 3)), int'($urandom_range(0, T - 1)), -1, -1);
        end
        do_reset();
        // random mix with timeouts and faults
        for (int i = 0; i < 250; i++) begin
            run_instr(1'($urandom), 1'($urandom), rand_wait(), int'($urandom_range(0, 3)),
                      rand_wait(),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1, -1);
            if (m_h) begin
                halt_cycles(int'($urandom_range(1, 3)));
                do_reset();
            end
        end

        guard = 0;
        while (expq.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (expq.size() > 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending want=0", expq.size());
        end
        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
